// File: rtl/cache_param_pkg.sv
// ---------------------------------------------------------------------------
// cache_param_pkg
// Shared definitions for the direct-mapped instruction cache:
//   - t_ic_state : controller state encoding
//   - f_off_w / f_idx_w / f_tag_w : address field widths derived from the
//     cache geometry (byte address, 32-bit words)
// ---------------------------------------------------------------------------
package cache_param_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MISS_REQ  = 3'd1,
        MISS_WAIT = 3'd2,
        FILL      = 3'd3,
        RESP      = 3'd4
    } t_ic_state;

    // Word-offset field width within a line.
    function automatic int f_off_w(input int line_words);
        return $clog2(line_words);
    endfunction

    // Line-index field width.
    function automatic int f_idx_w(input int num_lines);
        return $clog2(num_lines);
    endfunction

    // Tag is everything above byte, offset and index bits.
    function automatic int f_tag_w(input int addr_w, input int num_lines, input int line_words);
        return addr_w - 2 - $clog2(line_words) - $clog2(num_lines);
    endfunction

endpackage

// File: rtl/i_cache_line_array.sv
// ---------------------------------------------------------------------------
// i_cache_line_array
// Tag, valid and data storage for the direct-mapped cache.
//   clk, rst_n        : clock, async active-low reset (clears valid bits only)
//   i_rd_en, i_rd_idx : read strobe and line index; results registered
//   o_rd_valid/tag/data : line contents one cycle after i_rd_en
//   i_wr_en, i_wr_idx, i_wr_tag, i_wr_data : line write, sets valid bit
//   i_clr_all         : invalidate every line (wins over a write)
// Tag and data arrays carry no reset; valid bits gate every use of them.
// ---------------------------------------------------------------------------
module i_cache_line_array
    import cache_param_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int IDX_W      = f_idx_w(NUM_LINES)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_rd_en,
    input  logic [IDX_W-1:0]             i_rd_idx,
    output logic                         o_rd_valid,
    output logic [TAG_W-1:0]             o_rd_tag,
    output logic [WORD_W*LINE_WORDS-1:0] o_rd_data,
    input  logic                         i_wr_en,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [TAG_W-1:0]             i_wr_tag,
    input  logic [WORD_W*LINE_WORDS-1:0] i_wr_data,
    input  logic                         i_clr_all
);

    localparam int LINE_W = WORD_W * LINE_WORDS;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    r_data_mem [NUM_LINES];
    logic                 r_rd_valid;
    logic [TAG_W-1:0]     r_rd_tag;
    logic [LINE_W-1:0]    r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag_mem[i_wr_idx]  <= i_wr_tag;
            r_data_mem[i_wr_idx] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_tag  <= r_tag_mem[i_rd_idx];
            r_rd_data <= r_data_mem[i_rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (i_clr_all) begin
                r_valid <= '0;
            end else if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
            end
            if (i_rd_en) begin
                r_rd_valid <= r_valid[i_rd_idx] && !i_clr_all;
            end
        end
    end

    assign o_rd_valid = r_rd_valid;
    assign o_rd_tag   = r_rd_tag;
    assign o_rd_data  = r_rd_data;

endmodule

// File: rtl/i_cache_dm_param.sv
// ---------------------------------------------------------------------------
// i_cache_dm_param
// Parameterised direct-mapped instruction cache with a single outstanding
// line fill to fill memory (FM).
//   clk, rst_n                       : clock, async active-low reset
//   core_req_valid/addr/ready        : fetch request handshake
//   core_rsp_valid/data              : one-cycle response pulse, data held
//   flush                            : invalidate all lines
//   fm_req_valid/addr/ready          : line fill request handshake
//   fm_rsp_valid/data                : full line returned by FM
//   hit_cnt, miss_cnt                : saturating perf counters, present only
//                                      when I_CACHE_PERF_CNT_EN is defined
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | accepting requests; a request looks up the array the cycle
//           | after acceptance and either responds or leaves for MISS_REQ
// MISS_REQ  | fm_req_valid held with the line address until fm_req_ready
// MISS_WAIT | waiting for fm_rsp_valid, line captured when it arrives
// FILL      | captured line written to the array, valid bit set
// RESP      | requested word returned from the captured line
//
// Lookup happens in the cycle after acceptance because the array read is
// registered; while a lookup misses, core_req_ready drops so no second
// request slips in behind the miss.
// ---------------------------------------------------------------------------
module i_cache_dm_param
    import cache_param_pkg::*;
#(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         core_req_valid,
    input  logic [ADDR_W-1:0]            core_req_addr,
    output logic                         core_req_ready,
    output logic                         core_rsp_valid,
    output logic [31:0]                  core_rsp_data,
    input  logic                         flush,
    output logic                         fm_req_valid,
    output logic [ADDR_W-1:0]            fm_req_addr,
    input  logic                         fm_req_ready,
    input  logic                         fm_rsp_valid,
    input  logic [32*LINE_WORDS-1:0]     fm_rsp_data
`ifdef I_CACHE_PERF_CNT_EN
    ,
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt
`endif
);

    localparam int OFF_W   = f_off_w(LINE_WORDS);
    localparam int IDX_W   = f_idx_w(NUM_LINES);
    localparam int TAG_W   = f_tag_w(ADDR_W, NUM_LINES, LINE_WORDS);
    localparam int LINE_W  = WORD_W * LINE_WORDS;
    localparam int IDX_LSB = 2 + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    t_ic_state          r_state;
    t_ic_state          w_state_nxt;
    logic [ADDR_W-1:0]  r_req_addr;
    logic               r_lookup;
    logic               r_flush_pend;
    logic [LINE_W-1:0]  r_fill_data;
    logic [31:0]        r_rsp_hold;

    logic               w_rd_valid;
    logic [TAG_W-1:0]   w_rd_tag;
    logic [LINE_W-1:0]  w_rd_data;
    logic [OFF_W-1:0]   w_req_off;
    logic [IDX_W-1:0]   w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic [IDX_W-1:0]   w_in_idx;
    logic               w_hit;
    logic               w_lookup_miss;
    logic               w_accept;
    logic               w_clr_all;
    logic               w_wr_en;
    logic [LINE_W-1:0]  w_rsp_line;
    logic [31:0]        w_rsp_word;
    logic               w_unused_bits;

    assign w_req_off = r_req_addr[2 +: OFF_W];
    assign w_req_idx = r_req_addr[IDX_LSB +: IDX_W];
    assign w_req_tag = r_req_addr[TAG_LSB +: TAG_W];
    assign w_in_idx  = core_req_addr[IDX_LSB +: IDX_W];
    assign w_unused_bits = ^r_req_addr[1:0];

    // r_lookup is only ever set from IDLE and the FSM leaves IDLE only on the
    // lookup result, so a pending lookup always belongs to IDLE.
    assign w_hit         = r_lookup && w_rd_valid && (w_rd_tag == w_req_tag);
    assign w_lookup_miss = r_lookup && !w_hit;

    assign core_req_ready = rst_n && (r_state == IDLE) && !flush && !w_lookup_miss;
    assign w_accept       = core_req_valid && core_req_ready;

    // A flush outside IDLE is deferred so the in-flight fill completes and is
    // then wiped together with everything else on the way back to IDLE.
    assign w_clr_all = ((r_state == IDLE) && flush)
                     || ((r_state == RESP) && (r_flush_pend || flush));
    assign w_wr_en   = (r_state == FILL);

    i_cache_line_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W)
    ) u_line_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_rd_en    (w_accept),
        .i_rd_idx   (w_in_idx),
        .o_rd_valid (w_rd_valid),
        .o_rd_tag   (w_rd_tag),
        .o_rd_data  (w_rd_data),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (w_req_idx),
        .i_wr_tag   (w_req_tag),
        .i_wr_data  (r_fill_data),
        .i_clr_all  (w_clr_all)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:      if (w_lookup_miss) w_state_nxt = MISS_REQ;
            MISS_REQ:  if (fm_req_ready)  w_state_nxt = MISS_WAIT;
            MISS_WAIT: if (fm_rsp_valid)  w_state_nxt = FILL;
            FILL:      w_state_nxt = RESP;
            RESP:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_addr   <= '0;
            r_lookup     <= 1'b0;
            r_flush_pend <= 1'b0;
            r_fill_data  <= '0;
            r_rsp_hold   <= '0;
        end else begin
            r_lookup <= w_accept;
            if (w_accept) begin
                r_req_addr <= core_req_addr;
            end
            if ((r_state == MISS_WAIT) && fm_rsp_valid) begin
                r_fill_data <= fm_rsp_data;
            end
            if (r_state == RESP) begin
                r_flush_pend <= 1'b0;
            end else if (flush && (r_state != IDLE)) begin
                r_flush_pend <= 1'b1;
            end
            if (core_rsp_valid) begin
                r_rsp_hold <= w_rsp_word;
            end
        end
    end

    // Hits read from the array output; a miss answers from the captured line.
    assign w_rsp_line     = (r_state == RESP) ? r_fill_data : w_rd_data;
    assign w_rsp_word     = w_rsp_line[{w_req_off, 5'b0} +: 32];
    assign core_rsp_valid = (r_state == RESP) || w_hit;
    assign core_rsp_data  = core_rsp_valid ? w_rsp_word : r_rsp_hold;

    assign fm_req_valid = (r_state == MISS_REQ);
    assign fm_req_addr  = {w_req_tag, w_req_idx, {(OFF_W + 2){1'b0}}};

`ifdef I_CACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_lookup_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt  = r_hit_cnt;
    assign miss_cnt = r_miss_cnt;
`endif

endmodule
